// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory line responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BEAT
    } state_t;

    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_W    = 2;
    localparam int LINE_BASE_W = 8;
    localparam int LAT_W       = 4;
    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 32;
    localparam int BE_W        = 4;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: byte-enabled synchronous write, asynchronous read, never cleared by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [BE_W-1:0]          be,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_line_responder.sv
// Cache-side data memory responder: single reads, 4-beat line fills and byte writes
// with a programmable first-beat latency.
//
// state | meaning
// IDLE  | ready; writes commit here, reads are accepted here
// WAIT  | counting down the remaining access latency
// BEAT  | driving read beats, one per cycle, until the last one
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csn,
    input  logic                req,
    input  logic                wen,
    input  logic                burst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [BE_W-1:0]     be,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic [OFFSET_W-1:0] beat_idx,
    output logic                busy
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [OFFSET_W-1:0] LAST_OFF  = OFFSET_W'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0]    WAIT_INIT = LAT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    state_t                 state;
    logic [LAT_W-1:0]       lat_cnt;
    logic [LINE_BASE_W-1:0] line_base;
    logic [OFFSET_W-1:0]    beat_cnt;
    logic                   single_r;
    logic                   last_r;

    logic                   accept;
    logic                   do_write;
    logic                   do_read;
    logic [LINE_BASE_W-1:0] req_line;
    logic [OFFSET_W-1:0]    req_off;
    logic [LINE_BASE_W-1:0] rd_line;
    logic [OFFSET_W-1:0]    rd_off;
    logic [IDX_W-1:0]       rd_idx;
    logic [IDX_W-1:0]       wr_idx;
    logic [DATA_W-1:0]      rd_data;
    logic                   unused_addr;

    assign accept      = !csn && req && !busy;
    assign do_write    = accept && !wen;
    assign do_read     = accept && wen;
    assign req_line    = addr[ADDR_W-1:4];
    assign req_off     = burst ? '0 : addr[3:2];
    assign wr_idx      = IDX_W'(addr[ADDR_W-1:2]);
    assign unused_addr = ^addr[1:0];

    // Index of the word that will be driven at the coming edge.
    always_comb begin
        rd_line = line_base;
        rd_off  = beat_cnt;
        unique case (state)
            IDLE: begin
                rd_line = req_line;
                rd_off  = req_off;
            end
            WAIT: begin
                rd_line = line_base;
                rd_off  = beat_cnt;
            end
            BEAT: begin
                rd_line = line_base;
                rd_off  = beat_cnt + 1'b1;
            end
            default: begin
                rd_line = line_base;
                rd_off  = beat_cnt;
            end
        endcase
    end

    assign rd_idx = IDX_W'({rd_line, rd_off});

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (do_write),
        .widx (wr_idx),
        .be   (be),
        .wdata(din),
        .ridx (rd_idx),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            line_base  <= '0;
            beat_cnt   <= '0;
            single_r   <= 1'b0;
            last_r     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            beat_idx   <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (do_read) begin
                        line_base <= req_line;
                        beat_cnt  <= req_off;
                        single_r  <= !burst;
                        busy      <= 1'b1;
                        // Latency of one skips WAIT: the first beat is driven off this edge.
                        if (LATENCY <= 1) begin
                            state      <= BEAT;
                            dout       <= rd_data;
                            dout_valid <= 1'b1;
                            beat_idx   <= req_off;
                            last_r     <= !burst;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state      <= BEAT;
                        dout       <= rd_data;
                        dout_valid <= 1'b1;
                        beat_idx   <= beat_cnt;
                        last_r     <= single_r;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                BEAT: begin
                    if (last_r) begin
                        state      <= IDLE;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                        dout     <= rd_data;
                        beat_idx <= beat_cnt + 1'b1;
                        last_r   <= ((beat_cnt + 1'b1) == LAST_OFF);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed scoreboard bench: instance u0 (1024 words, latency 2) and u1 (256 words, latency 1).
module tb_dmem_line_responder;

    localparam int L0 = 2;
    localparam int L1 = 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  idx;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csn0, req0, wen0, burst0;
    logic [11:0] addr0;
    logic [3:0]  be0;
    logic [31:0] din0, dout0;
    logic        dv0, busy0;
    logic [1:0]  bi0;
    logic        csn1, req1, wen1, burst1;
    logic [11:0] addr1;
    logic [3:0]  be1;
    logic [31:0] din1, dout1;
    logic        dv1, busy1;
    logic [1:0]  bi1;

    int    cyc = 0;
    int    acc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    beat_t q0[$];
    beat_t q1[$];

    dmem_line_responder #(.DEPTH(1024), .LATENCY(L0)) u0 (
        .clk(clk), .rst_n(rst_n), .csn(csn0), .req(req0), .wen(wen0), .burst(burst0),
        .addr(addr0), .be(be0), .din(din0), .dout(dout0), .dout_valid(dv0),
        .beat_idx(bi0), .busy(busy0)
    );

    dmem_line_responder #(.DEPTH(256), .LATENCY(L1)) u1 (
        .clk(clk), .rst_n(rst_n), .csn(csn1), .req(req1), .wen(wen1), .burst(burst1),
        .addr(addr1), .be(be1), .din(din1), .dout(dout1), .dout_valid(dv1),
        .beat_idx(bi1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one request for a cycle; acc receives the cycle count of its edge.
    task automatic op(input int u, input logic c, input logic w, input logic b,
                      input logic [11:0] a, input logic [3:0] e, input logic [31:0] d);
        @(negedge clk);
        if (u == 0) begin
            csn0 = c; req0 = 1'b1; wen0 = w; burst0 = b; addr0 = a; be0 = e; din0 = d;
        end else begin
            csn1 = c; req1 = 1'b1; wen1 = w; burst1 = b; addr1 = a; be1 = e; din1 = d;
        end
        @(posedge clk);
        #1;
        acc  = cyc;
        req0 = 1'b0; csn0 = 1'b1;
        req1 = 1'b0; csn1 = 1'b1;
    endtask

    task automatic exp_beat(input int u, input logic [31:0] d, input logic [1:0] i, input int k);
        beat_t b;
        b.data = d;
        b.idx  = i;
        b.cyc  = acc + ((u == 0) ? L0 : L1) - 1 + k;
        if (u == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q0.size() + q1.size()) != 0; i++) begin
            @(negedge clk);
            #2;
        end
        chk("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dv0 === 1'b1) begin
                if (q0.size() == 0) begin
                    chk("u0_extra_beat", {31'b0, dv0}, 32'd0);
                end else begin
                    beat_t e;
                    e = q0.pop_front();
                    chk("u0_data", dout0, e.data);
                    chk("u0_beat_idx", {30'b0, bi0}, {30'b0, e.idx});
                    chk("u0_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (dv1 === 1'b1) begin
                if (q1.size() == 0) begin
                    chk("u1_extra_beat", {31'b0, dv1}, 32'd0);
                end else begin
                    beat_t e;
                    e = q1.pop_front();
                    chk("u1_data", dout1, e.data);
                    chk("u1_beat_idx", {30'b0, bi1}, {30'b0, e.idx});
                    chk("u1_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        csn0 = 1'b1; req0 = 1'b0; wen0 = 1'b1; burst0 = 1'b0; addr0 = '0; be0 = '0; din0 = '0;
        csn1 = 1'b1; req1 = 1'b0; wen1 = 1'b1; burst1 = 1'b0; addr1 = '0; be1 = '0; din1 = '0;
        idle(3);
        chk("rst_dout", dout0, 32'd0);
        chk("rst_valid", {31'b0, dv0}, 32'd0);
        chk("rst_beat_idx", {30'b0, bi0}, 32'd0);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_u1_valid", {31'b0, dv1}, 32'd0);
        chk("rst_u1_busy", {31'b0, busy1}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Write then single read, latency 2; then DOUT must hold with valid low.
        op(0, 1'b0, 1'b0, 1'b0, 12'h010, 4'hF, 32'hDEADBEEF);
        op(0, 1'b0, 1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        exp_beat(0, 32'hDEADBEEF, 2'd0, 0);
        drain();
        idle(1);
        chk("dout_hold", dout0, 32'hDEADBEEF);
        chk("valid_low_after", {31'b0, dv0}, 32'd0);

        // Byte enables.
        op(0, 1'b0, 1'b0, 1'b0, 12'h020, 4'hF, 32'h11223344);
        op(0, 1'b0, 1'b0, 1'b0, 12'h020, 4'b0101, 32'hAABBCCDD);
        op(0, 1'b0, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        exp_beat(0, 32'h11BB33DD, 2'd0, 0);
        drain();

        // Line fill from a mid-line address returns offsets 0..3.
        op(0, 1'b0, 1'b0, 1'b0, 12'h040, 4'hF, 32'hA0);
        op(0, 1'b0, 1'b0, 1'b0, 12'h044, 4'hF, 32'hA1);
        op(0, 1'b0, 1'b0, 1'b0, 12'h048, 4'hF, 32'hA2);
        op(0, 1'b0, 1'b0, 1'b0, 12'h04C, 4'hF, 32'hA3);
        op(0, 1'b0, 1'b1, 1'b1, 12'h048, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) exp_beat(0, 32'hA0 + 32'(k), 2'(k), k);
        for (int k = 1; k <= L0 + 4; k++) begin
            @(negedge clk);
            #2;
            chk("burst_busy", {31'b0, busy0}, {31'b0, (k <= L0 + 3)});
            chk("burst_valid", {31'b0, dv0}, {31'b0, (k >= L0 && k <= L0 + 3)});
        end
        chk("burst_done", 32'(q0.size()), 32'd0);

        // Read and write requests during BUSY are dropped.
        op(0, 1'b0, 1'b1, 1'b1, 12'h040, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) exp_beat(0, 32'hA0 + 32'(k), 2'(k), k);
        op(0, 1'b0, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
        op(0, 1'b0, 1'b0, 1'b0, 12'h040, 4'hF, 32'hFFFFFFFF);
        drain();
        idle(4);
        op(0, 1'b0, 1'b1, 1'b0, 12'h040, 4'h0, 32'h0);
        exp_beat(0, 32'hA0, 2'd0, 0);
        drain();

        // Chip select high: no write, no response.
        op(0, 1'b0, 1'b0, 1'b0, 12'h030, 4'hF, 32'h12345678);
        op(0, 1'b1, 1'b0, 1'b0, 12'h030, 4'hF, 32'h55555555);
        op(0, 1'b1, 1'b1, 1'b0, 12'h030, 4'h0, 32'h0);
        idle(6);
        op(0, 1'b0, 1'b1, 1'b0, 12'h030, 4'h0, 32'h0);
        exp_beat(0, 32'h12345678, 2'd0, 0);
        drain();

        // Reset after beat 1 of a burst.
        op(0, 1'b0, 1'b1, 1'b1, 12'h040, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) exp_beat(0, 32'hA0 + 32'(k), 2'(k), k);
        for (int i = 0; i < 20 && q0.size() > 2; i++) begin
            @(negedge clk);
            #2;
        end
        chk("rst_mid_reach", 32'(q0.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, dv0}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy0}, 32'd0);
        chk("rst_mid_dout", dout0, 32'd0);
        q0.delete();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        idle(5);
        op(0, 1'b0, 1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
        exp_beat(0, 32'hDEADBEEF, 2'd0, 0);
        drain();
        op(0, 1'b0, 1'b1, 1'b0, 12'h04C, 4'h0, 32'h0);
        exp_beat(0, 32'hA3, 2'd3, 0);
        drain();

        // Address wrap at 256 words, latency 1.
        op(1, 1'b0, 1'b0, 1'b0, 12'h010, 4'hF, 32'hCAFEF00D);
        op(1, 1'b0, 1'b1, 1'b0, 12'h410, 4'h0, 32'h0);
        exp_beat(1, 32'hCAFEF00D, 2'd0, 0);
        drain();
        op(1, 1'b0, 1'b0, 1'b0, 12'h81C, 4'hF, 32'h0BADC0DE);
        op(1, 1'b0, 1'b0, 1'b0, 12'h414, 4'hF, 32'h00000005);
        op(1, 1'b0, 1'b0, 1'b0, 12'h018, 4'hF, 32'h00000006);
        op(1, 1'b0, 1'b1, 1'b0, 12'h01C, 4'h0, 32'h0);
        exp_beat(1, 32'h0BADC0DE, 2'd3, 0);
        drain();
        op(1, 1'b0, 1'b1, 1'b1, 12'h41C, 4'h0, 32'h0);
        exp_beat(1, 32'hCAFEF00D, 2'd0, 0);
        exp_beat(1, 32'h00000005, 2'd1, 1);
        exp_beat(1, 32'h00000006, 2'd2, 2);
        exp_beat(1, 32'h0BADC0DE, 2'd3, 3);
        drain();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
